// File: rtl/gate_tree_if.sv
// ----------------------------------------------------------------------------
// gate_tree_if
//   Valid/ready bundle for gate_tree_pipe: the input transaction (channel
//   data, channel mask, op) and the reduced result (data, empty flag).
//
//   Signals
//     in_valid   producer -> block   input transaction valid
//     in_ready   block -> producer   block accepts input this cycle
//     in_data    producer -> block   channel k at bits [k*BITS +: BITS]
//     in_mask    producer -> block   1 = channel k participates
//     in_op      producer -> block   00 OR, 01 AND, 10 XOR, 11 PASS
//     out_valid  block -> consumer   result valid
//     out_ready  consumer -> block   consumer accepts result
//     out_data   block -> consumer   reduction result
//     out_empty  block -> consumer   1 = mask of this result was all zero
//
//   Modports
//     master  producer/consumer side (drives inputs, takes the result)
//     slave   the reduction block itself
// ----------------------------------------------------------------------------
interface gate_tree_if #(
    parameter int NUM  = 4,
    parameter int BITS = 32
);
    logic                in_valid;
    logic                in_ready;
    logic [NUM*BITS-1:0] in_data;
    logic [NUM-1:0]      in_mask;
    logic [1:0]          in_op;
    logic                out_valid;
    logic                out_ready;
    logic [BITS-1:0]     out_data;
    logic                out_empty;

    modport master (
        output in_valid, in_data, in_mask, in_op, out_ready,
        input  in_ready, out_valid, out_data, out_empty
    );

    modport slave (
        input  in_valid, in_data, in_mask, in_op, out_ready,
        output in_ready, out_valid, out_data, out_empty
    );
endinterface

// File: rtl/gate_tree_pipe.sv
// ----------------------------------------------------------------------------
// gate_tree_pipe
//   Pipelined, handshaked bitwise reduction of NUM channels of BITS each.
//   Each transaction carries its own op (OR / AND / XOR / PASS) and a
//   per-channel participation mask. One input stage masks the channels,
//   then LVL = clog2(NUM) tree stages each combine adjacent pairs; the
//   result appears LVL+1 cycles after acceptance.
//
//   Ports
//     clk       clock
//     rst       asynchronous reset, active-high
//     bus       gate_tree_if.slave: input transaction and result handshakes
//     done_cnt  saturating count of results accepted at the output
//
//   Flow control is a single global advance: every stage shifts when the
//   output register is empty or being taken, and everything holds otherwise.
//   in_ready is that advance term, so it depends combinationally on
//   out_ready, but no in_* signal reaches any out_* signal without a register.
// ----------------------------------------------------------------------------
module gate_tree_pipe #(
    parameter int NUM  = 4,
    parameter int BITS = 32,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    gate_tree_if.slave      bus,
    output logic [CNTW-1:0] done_cnt
);

    typedef enum logic [1:0] {
        OP_OR   = 2'b00,
        OP_AND  = 2'b01,
        OP_XOR  = 2'b10,
        OP_PASS = 2'b11
    } op_e;

    localparam int LVL = (NUM > 1) ? $clog2(NUM) : 0;

    // Number of lanes alive at stage j (stage 0 = input stage).
    function automatic int lanes(input int j);
        return (NUM + (1 << j) - 1) >> j;
    endfunction

    // Neutral element of the op; masked channels are replaced by it so the
    // tree never has to look at the mask for OR/AND/XOR.
    function automatic logic [BITS-1:0] ident(input logic [1:0] op);
        return (op == OP_AND) ? {BITS{1'b1}} : {BITS{1'b0}};
    endfunction

    // Combine one pair. Returns {participate flag, data}. For PASS the left
    // operand wins whenever it participates, which keeps the lowest
    // unmasked channel as the tree collapses.
    function automatic logic [BITS:0] combine(
        input logic [1:0]      op,
        input logic [BITS-1:0] a,
        input logic [BITS-1:0] b,
        input logic            pa,
        input logic            pb
    );
        logic [BITS-1:0] r;
        case (op)
            OP_OR:   r = a | b;
            OP_AND:  r = a & b;
            OP_XOR:  r = a ^ b;
            default: r = pa ? a : b;
        endcase
        return {pa | pb, r};
    endfunction

    // Saturating increment of the completion counter.
    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (&v) ? v : v + CNTW'(1);
    endfunction

    logic adv;

    for (genvar j = 0; j <= LVL; j++) begin : g_st
        localparam int LN = lanes(j);

        logic               vld_q;
        logic               vld_d;
        logic [LN*BITS-1:0] dat_q;
        logic [LN*BITS-1:0] dat_d;
        logic [LN-1:0]      prt_d;

        if (j == 0) begin : g_in
            // ---- input stage: mask substitution ----
            assign vld_d = bus.in_valid;
            assign prt_d = bus.in_mask;
            for (genvar k = 0; k < NUM; k++) begin : g_ch
                assign dat_d[k*BITS +: BITS] =
                    bus.in_mask[k] ? bus.in_data[k*BITS +: BITS] : ident(bus.in_op);
            end
        end else begin : g_tr
            // ---- tree stage j: combine pairs (2i, 2i+1) of stage j-1 ----
            localparam int PN = lanes(j - 1);
            assign vld_d = g_st[j-1].vld_q;
            for (genvar i = 0; i < LN; i++) begin : g_ln
                if (2*i + 1 < PN) begin : g_pair
                    assign {prt_d[i], dat_d[i*BITS +: BITS]} = combine(
                        g_st[j-1].g_ctl.op_q,
                        g_st[j-1].dat_q[(2*i)*BITS +: BITS],
                        g_st[j-1].dat_q[(2*i+1)*BITS +: BITS],
                        g_st[j-1].g_ctl.prt_q[2*i],
                        g_st[j-1].g_ctl.prt_q[2*i+1]);
                end else begin : g_odd
                    assign dat_d[i*BITS +: BITS] = g_st[j-1].dat_q[(2*i)*BITS +: BITS];
                    assign prt_d[i]              = g_st[j-1].g_ctl.prt_q[2*i];
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q <= 1'b0;
                dat_q <= '0;
            end else if (adv) begin
                vld_q <= vld_d;
                dat_q <= dat_d;
            end
        end

        if (j < LVL) begin : g_ctl
            // Op and participate flags are only needed by a following tree stage.
            logic [1:0]    op_d;
            logic [1:0]    op_q;
            logic [LN-1:0] prt_q;

            if (j == 0) begin : g_op0
                assign op_d = bus.in_op;
            end else begin : g_opn
                assign op_d = g_st[j-1].g_ctl.op_q;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    op_q  <= 2'b00;
                    prt_q <= '0;
                end else if (adv) begin
                    op_q  <= op_d;
                    prt_q <= prt_d;
                end
            end
        end else begin : g_fin
            // The final lane's participate flag is the OR of the whole mask.
            logic emp_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    emp_q <= 1'b0;
                end else if (adv) begin
                    emp_q <= ~prt_d[0];
                end
            end
        end
    end

    // ---- output stage / handshake ----
    assign adv           = ~g_st[LVL].vld_q | bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = g_st[LVL].vld_q;
    assign bus.out_data  = g_st[LVL].dat_q;
    assign bus.out_empty = g_st[LVL].g_fin.emp_q;

    logic [CNTW-1:0] done_q;
    logic [CNTW-1:0] done_d;

    always_comb begin
        done_d = done_q;
        if (bus.out_valid && bus.out_ready) begin
            done_d = sat_inc(done_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q <= '0;
        end else begin
            done_q <= done_d;
        end
    end

    assign done_cnt = done_q;

endmodule
